// File: rtl/spi_pkg.sv
// spi_pkg: shared state/mode types and default widths for the SPI master
package spi_pkg;
    typedef enum logic [2:0] {IDLE, CPHA_DELAY, P0, P1, SS_HOLD} spi_state_t;
    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;
    localparam int DATA_W_DEF = 8;
    localparam int DVSR_W_DEF = 16;
endpackage

// File: rtl/spi_half_period_cnt.sv
// spi_half_period_cnt: half-SCLK-period counter, tc when count reaches the divisor
module spi_half_period_cnt #(
    parameter int DVSR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DVSR_W-1:0] i_dvsr,
    output logic [DVSR_W-1:0] o_cnt,
    output logic              o_tc
);
    logic [DVSR_W-1:0] r_cnt;

    // count 0..dvsr while enabled, restart on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + DVSR_W'(1);
    end

    assign o_cnt = r_cnt;
    assign o_tc  = r_cnt == i_dvsr;
endmodule

// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master, all four modes, MSB/LSB first, auto slave select; SPI_LOOPBACK_EN adds internal loopback
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DVSR_W = DVSR_W_DEF,
    parameter int NUM_SS = 1,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [SS_W-1:0]   ss_sel,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              spi_done_tick,
    output logic              ready,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_t        r_state, w_state_nx;
    spi_mode_t         r_mode, w_mode;
    logic [DVSR_W-1:0] r_dvsr, w_cnt;
    logic [DATA_W-1:0] r_tx, r_rx, r_dout, w_tx_sh, w_rx_sh;
    logic [BIT_W-1:0]  r_bit;
    logic [NUM_SS-1:0] r_ss_n;
    logic              r_sclk, r_mosi, r_done, r_ready;
    logic              w_accept, w_tc, w_last, w_clr, w_done_nx, w_pclk;
    logic              w_loop, w_loop_nx, w_tx_bit, w_rx_in;

`ifdef SPI_LOOPBACK_EN
    logic r_loop;
    // loopback choice is frozen for the whole transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_loop <= 1'b0;
        else if (w_accept) r_loop <= loopback;
    end
    assign w_loop    = r_loop;
    assign w_loop_nx = w_accept ? loopback : r_loop;
`else
    assign w_loop    = 1'b0;
    assign w_loop_nx = 1'b0;
`endif

    spi_half_period_cnt #(.DVSR_W(DVSR_W)) u_cnt (
        .clk(clk), .reset_n(reset_n), .i_clr(w_clr), .i_en(r_state != IDLE),
        .i_dvsr(r_dvsr), .o_cnt(w_cnt), .o_tc(w_tc)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_mode   = w_accept ? {cpol, cpha, lsb_first} : r_mode;
    assign w_last   = r_bit == BIT_W'(DATA_W - 1);
    assign w_clr    = w_accept || ((r_state != IDLE) && w_tc);
    assign w_tx_bit = r_mode.lsb_first ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_sh  = r_mode.lsb_first ? r_tx >> 1 : r_tx << 1;
    assign w_rx_in  = w_loop ? w_tx_bit : miso;
    assign w_rx_sh  = r_mode.lsb_first ? {w_rx_in, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_rx_in};
    // done (and ss release) lands on the final cycle of SS_HOLD
    assign w_done_nx = ((r_state == P1) && w_tc && w_last && (r_dvsr == '0)) ||
                       ((r_state == SS_HOLD) && !w_tc && (w_cnt + DVSR_W'(1) == r_dvsr));
    assign w_pclk    = ((w_state_nx == P1) && !w_mode.cpha) || ((w_state_nx == P0) && w_mode.cpha);

    // next-state decode, also feeds the registered sclk lookahead
    always_comb begin
        w_state_nx = r_state;
        if (w_accept) w_state_nx = cpha ? CPHA_DELAY : P0;
        else if ((r_state != IDLE) && w_tc)
            w_state_nx = (r_state == CPHA_DELAY) ? P0 :
                         (r_state == P0)         ? P1 :
                         (r_state == P1)         ? (w_last ? SS_HOLD : P0) : IDLE;
    end

    // FSM with registered bus outputs, shift registers and select decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_dvsr  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dout  <= '0;
            r_bit   <= '0;
            r_ss_n  <= '1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_sclk  <= w_mode.cpol ^ w_pclk;
            r_done  <= w_done_nx;
            r_ready <= w_state_nx == IDLE;
            if (w_accept) begin
                r_mode <= w_mode;
                r_dvsr <= dvsr;
                r_tx   <= din;
                r_bit  <= '0;
                r_mosi <= !w_loop_nx && (lsb_first ? din[0] : din[DATA_W-1]);
                r_ss_n <= w_loop_nx ? '1 : ~(NUM_SS'(1) << ss_sel);
            end
            if ((r_state == P0) && w_tc) r_rx <= w_rx_sh;
            if ((r_state == P1) && w_tc && !w_last) begin
                r_tx   <= w_tx_sh;
                r_bit  <= r_bit + BIT_W'(1);
                r_mosi <= !w_loop && (r_mode.lsb_first ? w_tx_sh[0] : w_tx_sh[DATA_W-1]);
            end
            if (w_done_nx) begin
                r_ss_n <= '1;
                r_dout <= r_rx;
            end
        end
    end

    assign dout          = r_dout;
    assign spi_done_tick = r_done;
    assign ready         = r_ready;
    assign sclk          = r_sclk;
    assign mosi          = r_mosi;
    assign ss_n          = r_ss_n;
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: vector table, random transfers against a behavioural SPI slave, and corner sequences
module tb_spi_master_gen;
    localparam int NSS = 5;
    logic clk = 0, reset_n = 0, start = 0, cpol = 0, cpha = 0, lsb_first = 0;
    logic miso, sclk, mosi, spi_done_tick, ready;
    logic [7:0] din = 0, dout;
    logic [15:0] dvsr = 0;
    logic [2:0] ss_sel = 0;
    logic [NSS-1:0] ss_n;
    bit tie = 0, force0 = 0;
`ifdef SPI_LOOPBACK_EN
    logic loopback = 0;
`endif
    logic [7:0] s_word = 0, s_rx = 0;
    logic s_prev = 0, s_bit = 0;
    int s_k = 0;
    int n_pass = 0, n_tot = 0;
    logic [7:0] got;
    int lat;
    logic [NSS-1:0] ss_first, ss_done;
    bit ss_const, mosi_hi;
    logic rdy_done, rdy_after, sclk_idle;

    typedef struct {
        logic [7:0] d, w;
        logic pol, pha, lsb;
        int dv, sel;
        bit t;
        logic [7:0] e_dout;
        int e_lat;
        logic [NSS-1:0] e_ss;
    } vec_t;
    vec_t vt [5];

    assign miso = force0 ? 1'b0 : tie ? mosi : s_bit;
    always #5 clk = ~clk;

    spi_master_gen #(.DATA_W(8), .DVSR_W(16), .NUM_SS(NSS)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .dvsr(dvsr), .start(start),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .ss_sel(ss_sel),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .dout(dout), .spi_done_tick(spi_done_tick), .ready(ready), .sclk(sclk),
        .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    // SPI slave: shifts out s_word and captures mosi, following the standard mode edge rules
    always @(negedge clk) begin
        if (&ss_n) begin
            s_k = cpha ? -1 : 0;
            s_prev = cpol;
        end else begin
            if (sclk !== s_prev) begin
                if ((sclk !== cpol) != cpha) s_rx = lsb_first ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
                else s_k++;
            end
            s_prev = sclk;
        end
        s_bit = (s_k < 0 || s_k > 7) ? 1'b0 : s_word[lsb_first ? s_k : 7 - s_k];
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic xfer(input logic [7:0] d, input logic [7:0] w, input logic pol, input logic pha,
                        input logic lsb, input int dv, input int sel, input bit t);
        int n;
        @(negedge clk);
        din = d; s_word = w; cpol = pol; cpha = pha; lsb_first = lsb;
        dvsr = 16'(dv); ss_sel = 3'(sel); tie = t;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0; ss_first = ss_n; ss_const = 1; mosi_hi = 0;
        while (!spi_done_tick && n < 400) begin
            if (ss_n !== ss_first) ss_const = 0;
            mosi_hi |= mosi;
            @(negedge clk);
            n++;
        end
        lat = n + 1; got = dout; ss_done = ss_n; rdy_done = ready;
        @(negedge clk);
        rdy_after = ready; sclk_idle = sclk;
    endtask

    initial begin
        logic [7:0] d, w, d1, d2;
        logic pol, pha, lsb;
        int dv, sel, n, hi, nd;
        bit t;
        logic [NSS-1:0] e_ss;
        vt[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0, 1, 8'hA5, 34, 5'b11110};
        vt[1] = '{8'h11, 8'h3C, 1'b1, 1'b1, 1'b1, 1, 1, 0, 8'h3C, 36, 5'b11101};
        vt[2] = '{8'hC3, 8'h96, 1'b0, 1'b1, 1'b0, 0, 2, 0, 8'h96, 18, 5'b11011};
        vt[3] = '{8'h7E, 8'h81, 1'b1, 1'b0, 1'b1, 2, 3, 0, 8'h81, 51, 5'b10111};
        vt[4] = '{8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1, 3, 4, 0, 8'hF0, 68, 5'b01111};
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_ss_n", ss_n, 5'h1F);
        chk("rst_mosi", mosi, 0);
        chk("rst_dout", dout, 0);
        chk("rst_done", spi_done_tick, 0);

        for (int i = 0; i < 5; i++) begin
            xfer(vt[i].d, vt[i].w, vt[i].pol, vt[i].pha, vt[i].lsb, vt[i].dv, vt[i].sel, vt[i].t);
            chk($sformatf("vec%0d_dout", i), got, vt[i].e_dout);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].e_lat);
            chk($sformatf("vec%0d_ss_n", i), ss_first, vt[i].e_ss);
            chk($sformatf("vec%0d_ss_stable", i), ss_const, 1);
            chk($sformatf("vec%0d_ss_at_done", i), ss_done, 5'h1F);
            chk($sformatf("vec%0d_ready_at_done", i), rdy_done, 0);
            chk($sformatf("vec%0d_ready_after", i), rdy_after, 1);
            chk($sformatf("vec%0d_sclk_idle", i), sclk_idle, vt[i].pol);
            chk($sformatf("vec%0d_slave_rx", i), s_rx, vt[i].d);
        end

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom); w = 8'($urandom);
            pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1)); lsb = 1'($urandom_range(0, 1));
            dv = $urandom_range(0, 3); sel = $urandom_range(0, NSS - 1); t = ($urandom_range(0, 3) == 0);
            xfer(d, w, pol, pha, lsb, dv, sel, t);
            e_ss = '1;
            e_ss[sel] = 1'b0;
            chk($sformatf("rnd%0d_dout", i), got, t ? d : w);
            chk($sformatf("rnd%0d_latency", i), lat, (2 * 8 + 1 + int'(pha)) * (dv + 1));
            chk($sformatf("rnd%0d_ss_n", i), ss_first, e_ss);
            chk($sformatf("rnd%0d_slave_rx", i), s_rx, d);
            chk($sformatf("rnd%0d_sclk_idle", i), sclk_idle, pol);
        end

        for (int s = NSS; s < 8; s++) begin
            xfer(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 0, s, 0);
            chk($sformatf("oor%0d_ss_n", s), ss_first, 5'h1F);
            chk($sformatf("oor%0d_ss_stable", s), ss_const, 1);
            chk($sformatf("oor%0d_latency", s), lat, 17);
        end

        @(negedge clk);
        cpol = 0; cpha = 0; lsb_first = 0; dvsr = 0; ss_sel = 0; tie = 1; din = 8'h3C;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        din = 8'hC5;
        n = 0;
        while (!spi_done_tick && n < 200) begin @(negedge clk); n++; end
        d1 = dout;
        hi = 0; n = 0;
        while (&ss_n && n < 200) begin hi++; @(negedge clk); n++; end
        start = 0;
        n = 0;
        while (!spi_done_tick && n < 200) begin @(negedge clk); n++; end
        d2 = dout;
        chk("b2b_first_dout", d1, 8'h3C);
        chk("b2b_second_dout", d2, 8'hC5);
        chk("b2b_ss_gap", hi, 2);
        chk("b2b_done_spacing", hi + n, 18);
        @(negedge clk);
        tie = 0;

`ifdef SPI_LOOPBACK_EN
        loopback = 1; force0 = 1;
        xfer(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0, 0);
        chk("lb_dout", got, 8'h5A);
        chk("lb_mosi_low", mosi_hi, 0);
        chk("lb_ss_n", ss_first, 5'h1F);
        chk("lb_latency", lat, 34);
        loopback = 0; force0 = 0;
`endif

        @(negedge clk);
        din = 8'h96; cpol = 1; cpha = 0; lsb_first = 0; dvsr = 1; ss_sel = 1; tie = 1;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (13) @(negedge clk);
        chk("abort_busy", ready, 0);
        reset_n = 0;
        #1;
        chk("abort_sclk", sclk, 0);
        chk("abort_ss_n", ss_n, 5'h1F);
        chk("abort_mosi", mosi, 0);
        chk("abort_dout", dout, 0);
        chk("abort_done", spi_done_tick, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        nd = 0;
        repeat (80) begin @(negedge clk); if (spi_done_tick) nd++; end
        chk("abort_no_done", nd, 0);
        chk("abort_sclk_idle", sclk, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
